// File: rtl/eth_rx_pkg.sv
// Shared types for the Ethernet RX packer: FSM state encoding, status word layout
// and the reported-length helper.
package eth_rx_pkg;

    localparam int LEN_W   = 11;
    localparam int ST_ERR  = 15;
    localparam int ST_OVF  = 14;
    localparam int ST_RUNT = 13;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RECV = 3'd1,
        S_DROP = 3'd2,
        S_STAT = 3'd3,
        S_DONE = 3'd4,
        S_WAIT = 3'd5
    } state_e;

    // Length reported in the status word; optionally excludes the 4-byte FCS.
    function automatic logic [LEN_W-1:0] frame_len(input logic [LEN_W-1:0] cnt,
                                                  input logic strip);
        logic [LEN_W-1:0] len;
        if (!strip) begin
            len = cnt;
        end else if (cnt < LEN_W'(4)) begin
            len = '0;
        end else begin
            len = cnt - LEN_W'(4);
        end
        return len;
    endfunction

endpackage

// File: rtl/rx_byte_pack.sv
// Pairs received bytes into little-endian 16-bit words; a lone final byte
// is flushed with a zero high byte.
module rx_byte_pack (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vld_i,
    input  logic [7:0]  dat_i,
    input  logic        eop_i,
    output logic        word_vld_o,
    output logic [15:0] word_o
);

    logic       phase_q, phase_d;
    logic [7:0] lo_q, lo_d;

    // Word completes on the high byte, or early on an end-of-frame low byte.
    always_comb begin
        phase_d    = phase_q;
        lo_d       = lo_q;
        word_vld_o = 1'b0;
        word_o     = 16'h0000;
        if (vld_i) begin
            if (phase_q) begin
                word_vld_o = 1'b1;
                word_o     = {dat_i, lo_q};
                phase_d    = 1'b0;
            end else begin
                lo_d = dat_i;
                if (eop_i) begin
                    word_vld_o = 1'b1;
                    word_o     = {8'h00, dat_i};
                    phase_d    = 1'b0;
                end else begin
                    phase_d = 1'b1;
                end
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Phase and held low byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            lo_q    <= 8'h00;
        end else begin
            phase_q <= phase_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: rtl/eth_rx_packer.sv
// Ethernet RX packer: writes one frame per buffer grant, then a status/length word at address 0.
// Optional macro ETH_RX_CRCSTRIP_EN: status length excludes the 4 FCS bytes (FCS still stored).
module eth_rx_packer
    import eth_rx_pkg::*;
#(
    parameter int AW     = 10,
    parameter int MINLEN = 64
) (
    input  logic          eth_clk_i,
    input  logic          eth_rst_i,
    input  logic          rx_dv_i,
    input  logic [7:0]    rx_dat_i,
    input  logic          rx_eop_i,
    input  logic          rx_err_i,
    input  logic          buf_rdy_i,
    output logic [AW-1:0] eth_adr_o,
    output logic [15:0]   eth_dat_o,
    output logic          eth_we_o,
    output logic          done_o,
    output logic          busy_o,
    output logic [7:0]    drop_cnt_o
);

`ifdef ETH_RX_CRCSTRIP_EN
    localparam logic STRIP = 1'b1;
`else
    localparam logic STRIP = 1'b0;
`endif
    localparam logic [LEN_W-1:0] CNT_MAX  = {LEN_W{1'b1}};
    localparam logic [11:0]      WMAX     = 12'((1 << AW) - 1);
    localparam logic [LEN_W-1:0] RUNT_LEN = LEN_W'(MINLEN);

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic             err_q, ovf_q;
    logic [AW-1:0]    adr_q;
    logic [15:0]      dat_q;
    logic             we_q, done_q, busy_q;
    logic [7:0]       drop_q;

    logic             take_s, in_range_s, word_vld_s;
    logic [15:0]      word_s, stat_s;
    logic [11:0]      widx_s;
    logic [LEN_W-1:0] len_s;

    rx_byte_pack u_pack (
        .clk_i      (eth_clk_i),
        .rst_i      (eth_rst_i),
        .vld_i      (take_s),
        .dat_i      (rx_dat_i),
        .eop_i      (rx_eop_i),
        .word_vld_o (word_vld_s),
        .word_o     (word_s)
    );

    // Byte acceptance, buffer range check and status word assembly.
    always_comb begin
        take_s     = rx_dv_i & ((state_q == S_RECV) | ((state_q == S_IDLE) & buf_rdy_i));
        widx_s     = {2'b00, cnt_q[LEN_W-1:1]};
        in_range_s = (widx_s < WMAX) & (cnt_q != CNT_MAX);
        len_s      = frame_len(cnt_q, STRIP);
        stat_s              = 16'h0000;
        stat_s[LEN_W-1:0]   = len_s;
        stat_s[ST_ERR]      = err_q;
        stat_s[ST_OVF]      = ovf_q;
        stat_s[ST_RUNT]     = (len_s < RUNT_LEN);
    end

    // Frame FSM with registered buffer-write, handshake and counter outputs.
    always_ff @(posedge eth_clk_i) begin
        if (eth_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= 16'h0000;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 8'h00;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (take_s) begin
                cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + LEN_W'(1);
                if (!in_range_s) ovf_q <= 1'b1;
            end
            if (rx_err_i && (take_s || state_q == S_RECV)) err_q <= 1'b1;
            // Data words land at word index + 1; word 0 is reserved for status.
            if (word_vld_s && in_range_s) begin
                we_q  <= 1'b1;
                adr_q <= AW'(widx_s + 12'd1);
                dat_q <= word_s;
            end
            case (state_q)
                S_IDLE: begin
                    if (rx_dv_i && buf_rdy_i) begin
                        state_q <= rx_eop_i ? S_STAT : S_RECV;
                        busy_q  <= 1'b1;
                    end else if (rx_dv_i) begin
                        drop_q  <= (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                        state_q <= rx_eop_i ? S_IDLE : S_DROP;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RECV: begin
                    busy_q <= 1'b1;
                    if (rx_dv_i && rx_eop_i) state_q <= S_STAT;
                end
                S_STAT: begin
                    we_q    <= 1'b1;
                    adr_q   <= '0;
                    dat_q   <= stat_s;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    ovf_q   <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (rx_dv_i) begin
                        drop_q <= (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                        if (rx_eop_i) state_q <= buf_rdy_i ? S_WAIT : S_IDLE;
                        else          state_q <= S_DROP;
                    end else if (!buf_rdy_i) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (rx_dv_i && rx_eop_i) state_q <= buf_rdy_i ? S_WAIT : S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign eth_adr_o  = adr_q;
    assign eth_dat_o  = dat_q;
    assign eth_we_o   = we_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_eth_rx_packer.sv
// Randomized scoreboard bench for eth_rx_packer; two instances (AW=10 and AW=4)
// see identical stimulus and are checked against a frame-level model.
module tb_eth_rx_packer;

    typedef struct packed {
        logic        is_done;
        logic [15:0] adr;
        logic [15:0] dat;
    } exp_t;

`ifdef ETH_RX_CRCSTRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx_dv, rx_eop, rx_err, buf_rdy;
    logic [7:0] rx_dat;
    logic [9:0] a_adr;
    logic [3:0] b_adr;
    logic [15:0] a_dat, b_dat;
    logic       a_we, b_we, a_done, b_done, a_busy, b_busy;
    logic [7:0] a_drop, b_drop;

    eth_rx_packer #(.AW(10), .MINLEN(64)) u_dut (
        .eth_clk_i(clk), .eth_rst_i(rst), .rx_dv_i(rx_dv), .rx_dat_i(rx_dat),
        .rx_eop_i(rx_eop), .rx_err_i(rx_err), .buf_rdy_i(buf_rdy),
        .eth_adr_o(a_adr), .eth_dat_o(a_dat), .eth_we_o(a_we), .done_o(a_done),
        .busy_o(a_busy), .drop_cnt_o(a_drop)
    );

    eth_rx_packer #(.AW(4), .MINLEN(64)) u_dut4 (
        .eth_clk_i(clk), .eth_rst_i(rst), .rx_dv_i(rx_dv), .rx_dat_i(rx_dat),
        .rx_eop_i(rx_eop), .rx_err_i(rx_err), .buf_rdy_i(buf_rdy),
        .eth_adr_o(b_adr), .eth_dat_o(b_dat), .eth_we_o(b_we), .done_o(b_done),
        .busy_o(b_busy), .drop_cnt_o(b_drop)
    );

    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] fb[$];
    int         checks   = 0;
    int         failures = 0;
    int         exp_drop = 0;
    bit         m_wait   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int which, input exp_t e);
        if (which == 0) qa.push_back(e);
        else            qb.push_back(e);
    endtask

    // Frame-level reference: byte pairs into words, capacity limit, status rules.
    task automatic expect_frame(input int aw, input int which, input int n,
                                input bit err, input bit complete);
        int         nw   = (n + 1) / 2;
        int         maxw = (1 << aw) - 1;
        int         len;
        logic [7:0] hi;
        exp_t       e;
        for (int w = 1; w <= nw && w <= maxw; w++) begin
            hi = (2 * w - 1 < n) ? fb[2*w-1] : 8'h00;
            e  = '{1'b0, 16'(w), {hi, fb[2*w-2]}};
            push_exp(which, e);
        end
        if (complete) begin
            len = (n > 2047) ? 2047 : n;
            if (STRIP) len = (len >= 4) ? len - 4 : 0;
            e = '{1'b0, 16'h0000, {err, nw > maxw, len < 64, 2'b00, 11'(len)}};
            push_exp(which, e);
            e = '{1'b1, 16'h0000, 16'h0000};
            push_exp(which, e);
        end
    endtask

    task automatic mon_evt(input int which, input string tag, input exp_t act);
        exp_t e;
        int   sz = (which == 0) ? qa.size() : qb.size();
        if (sz == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected actual=0x%0h required=none", tag, act);
        end else begin
            e = (which == 0) ? qa.pop_front() : qb.pop_front();
            check(tag, 64'(act), 64'(e));
        end
    endtask

    task automatic monitor();
        bit pa = 1'b0;
        bit pb = 1'b0;
        forever begin
            @(negedge clk);
            if (a_we)   mon_evt(0, "aw10_write", '{1'b0, 16'(a_adr), a_dat});
            if (a_done) begin
                mon_evt(0, "aw10_done", '{1'b1, 16'h0000, 16'h0000});
                check("aw10_done_after_status", 64'(pa), 64'd1);
            end
            if (b_we)   mon_evt(1, "aw4_write", '{1'b0, 16'(b_adr), b_dat});
            if (b_done) begin
                mon_evt(1, "aw4_done", '{1'b1, 16'h0000, 16'h0000});
                check("aw4_done_after_status", 64'(pb), 64'd1);
            end
            pa = a_we && (a_adr == 10'd0);
            pb = b_we && (b_adr == 4'd0);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_inc(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic gap(input int n, input bit rdy);
        buf_rdy = rdy;
        repeat (n) cyc();
        if (!rdy) m_wait = 1'b0;
        check("aw10_drop_cnt", 64'(a_drop), 64'(exp_drop));
        check("aw4_drop_cnt", 64'(b_drop), 64'(exp_drop));
    endtask

    // Drive the frame held in fb; err_idx >= 1 pulses rx_err on that byte.
    task automatic send_frame(input bit rdy, input int err_idx, input bit stall, input bit toggle);
        int n     = fb.size();
        bit owned = rdy && !m_wait;
        bit ehit  = (err_idx >= 1) && (err_idx < n);
        if (owned) begin
            expect_frame(10, 0, n, ehit, 1'b1);
            expect_frame(4, 1, n, ehit, 1'b1);
        end
        buf_rdy = rdy;
        for (int i = 0; i < n; i++) begin
            while (stall && i > 0 && $urandom_range(0, 3) == 0) begin
                rx_dv  = 1'b0;
                rx_dat = 8'($urandom_range(0, 255));
                rx_eop = 1'($urandom_range(0, 1));
                rx_err = 1'b0;
                cyc();
            end
            rx_dv  = 1'b1;
            rx_dat = fb[i];
            rx_eop = (i == n - 1);
            rx_err = (i == err_idx);
            if (toggle && owned && i > 0) buf_rdy = 1'($urandom_range(0, 1));
            cyc();
            if (i == 0) begin
                check("aw10_busy", 64'(a_busy), 64'(owned));
                check("aw4_busy", 64'(b_busy), 64'(owned));
            end
        end
        rx_dv  = 1'b0;
        rx_eop = 1'b0;
        rx_err = 1'b0;
        if (owned) begin
            m_wait = 1'b1;
        end else begin
            exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
            m_wait   = rdy;
        end
    endtask

    initial begin
        rst = 1'b1; rx_dv = 1'b0; rx_dat = 8'h00; rx_eop = 1'b0; rx_err = 1'b0; buf_rdy = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) cyc();
        check("reset_aw10_outs", {a_we, a_done, a_busy, a_drop, 6'd0, a_adr, a_dat},
              64'd0);
        check("reset_aw4_outs", {b_we, b_done, b_busy, b_drop, 4'd0, b_adr, b_dat}, 64'd0);
        rst = 1'b0;
        gap(2, 1'b0);

        fill_inc(64);  send_frame(1'b1, -1, 1'b0, 1'b0); gap(6, 1'b0);
        fill_inc(61);  send_frame(1'b1, -1, 1'b0, 1'b0); gap(6, 1'b0);
        fill_rand(100); send_frame(1'b1, 50, 1'b0, 1'b0); gap(6, 1'b0);
        fill_rand(70); send_frame(1'b0, -1, 1'b0, 1'b0); gap(6, 1'b0);
        fill_rand(20); send_frame(1'b1, -1, 1'b1, 1'b1); gap(6, 1'b1);
        fill_rand(30); send_frame(1'b1, -1, 1'b0, 1'b0); gap(6, 1'b1);
        gap(3, 1'b0);
        fill_inc(40);  send_frame(1'b1, -1, 1'b0, 1'b0); gap(6, 1'b0);
        fill_rand(1);  send_frame(1'b1, -1, 1'b0, 1'b0); gap(6, 1'b0);
        fill_rand(2);  send_frame(1'b1, 1, 1'b0, 1'b0); gap(6, 1'b0);
        fill_rand(2050); send_frame(1'b1, -1, 1'b0, 1'b0); gap(6, 1'b0);

        // Reset in the middle of a granted frame: only the completed words appear.
        fill_inc(10);
        expect_frame(10, 0, 10, 1'b0, 1'b0);
        expect_frame(4, 1, 10, 1'b0, 1'b0);
        buf_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rx_dv = 1'b1; rx_dat = fb[i]; rx_eop = 1'b0;
            cyc();
        end
        rx_dv = 1'b0; rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0; exp_drop = 0; m_wait = 1'b0;
        check("aw10_reset_queue", 64'(qa.size()), 64'd0);
        check("aw4_reset_queue", 64'(qb.size()), 64'd0);
        gap(3, 1'b0);
        fill_inc(64);  send_frame(1'b1, -1, 1'b0, 1'b0); gap(6, 1'b0);

        // Back-to-back one-byte frames without a buffer drive the counter into saturation.
        for (int k = 0; k < 260; k++) begin
            fill_rand(1);
            send_frame(1'b0, -1, 1'b0, 1'b0);
        end
        gap(2, 1'b0);

        for (int k = 0; k < 40; k++) begin
            fill_rand($urandom_range(0, 7) == 0 ? $urandom_range(1, 4) : $urandom_range(1, 150));
            send_frame(1'($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 2) == 0) ? $urandom_range(1, 150) : -1,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            gap(6, 1'($urandom_range(0, 2) == 0));
        end

        gap(10, 1'b0);
        check("aw10_queue_empty", 64'(qa.size()), 64'd0);
        check("aw4_queue_empty", 64'(qb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
